// File: rtl/host_ack_pkg.sv
// Shared RVVI receive-frame definitions: beat indices, parser states and the
// minimal core-config view needed by the packetizer, depacketizer and triggergen.
package host_ack_pkg;

    // Only the XLEN field of the core configuration is consumed by these blocks.
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    // Beats 0..HDR_BEATS-1 carry MACs, EtherType and tag; payload starts after.
    localparam logic [3:0] HDR_BEATS    = 4'd5;
    localparam logic [3:0] PAYLOAD_BASE = 4'd5;

    typedef enum logic [1:0] {HDR, PAYLOAD, TAIL, DROP} rxparse_state_t;

    // Beats needed to carry a full frame: IPD plus one or two Minstr words.
    function automatic logic [3:0] rx_nbeats(input int unsigned xlen);
        return (xlen == 64) ? 4'd8 : 4'd7;
    endfunction

endpackage

// File: rtl/host_ack_depacketizer_satcnt.sv
// Saturating up-counter used for the good/dropped frame statistics.
module satcnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;

    // Count up on each increment request, holding once all ones is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/host_ack_depacketizer.sv
// Host acknowledge frame parser on the MAC RX stream. Header words are matched
// against a parameter-derived table; payload is captured in shadow registers
// and only published (with a Valid pulse) once the frame is known to be good.
module host_ack_depacketizer
    import host_ack_pkg::*;
#(
    parameter cvw_t        P         = '{XLEN: 64},
    parameter logic [47:0] DST_MAC   = 48'h8F54_0000_1654,
    parameter logic [47:0] SRC_MAC   = 48'h4502_1111_6843,
    parameter logic [15:0] ETH_TYPE  = 16'h005c,
    parameter logic [31:0] TAG       = 32'h6e6b_6361,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          RvviAxiRdata,
    input  logic [3:0]           RvviAxiRstrb,
    input  logic                 RvviAxiRlast,
    input  logic                 RvviAxiRvalid,
    output logic                 Valid,
    output logic [P.XLEN-1:0]    Minstr,
    output logic [31:0]          InterPacketDelay,
    output logic [CNT_WIDTH-1:0] GoodFrames,
    output logic [CNT_WIDTH-1:0] DroppedFrames
);

    localparam logic [3:0] NBEATS    = rx_nbeats(P.XLEN);
    localparam logic [3:0] LAST_BEAT = NBEATS - 4'd1;

    localparam logic [31:0] HDR_TBL [5] = '{
        DST_MAC[31:0],
        {SRC_MAC[15:0], DST_MAC[47:32]},
        SRC_MAC[47:16],
        {TAG[15:0], ETH_TYPE},
        {16'h0, TAG[31:16]}
    };

    rxparse_state_t state_q, state_d;
    logic [3:0]     beat_q, beat_d;
    logic [31:0]    ipd_sh_q, ipd_sh_d;
    logic [63:0]    min_sh_q, min_sh_d;
    logic [31:0]    ipd_q;
    logic [63:0]    minstr_q;
    logic           valid_q;
    logic           good_d, drop_d;
    logic [31:0]    hdr_exp;
    logic           strb_full, hdr_ok;

    // Expected header word for the current beat; the tag's upper beat only
    // carries 16 meaningful bits, so only its low half and low strobes matter.
    always_comb begin
        hdr_exp = '0;
        if (beat_q < HDR_BEATS) begin
            hdr_exp = HDR_TBL[beat_q[2:0]];
        end
        strb_full = (RvviAxiRstrb == 4'hF);
        if (beat_q == HDR_BEATS - 4'd1) begin
            hdr_ok = (RvviAxiRstrb[1:0] == 2'b11) && (RvviAxiRdata[15:0] == hdr_exp[15:0]);
        end else begin
            hdr_ok = strb_full && (RvviAxiRdata == hdr_exp);
        end
    end

    // Parser next state, beat counting, payload capture and frame verdict.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        ipd_sh_d = ipd_sh_q;
        min_sh_d = min_sh_q;
        good_d   = 1'b0;
        drop_d   = 1'b0;
        if (RvviAxiRvalid) begin
            if (beat_q != NBEATS) begin
                beat_d = beat_q + 4'd1;
            end
            unique case (state_q)
                HDR: begin
                    if (!hdr_ok) begin
                        state_d = DROP;
                    end else if (beat_q == HDR_BEATS - 4'd1) begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!strb_full) begin
                        state_d = DROP;
                    end else begin
                        if (beat_q == PAYLOAD_BASE) begin
                            ipd_sh_d = RvviAxiRdata;
                        end else if (beat_q == PAYLOAD_BASE + 4'd1) begin
                            min_sh_d[31:0] = RvviAxiRdata;
                        end else begin
                            min_sh_d[63:32] = RvviAxiRdata;
                        end
                        if (beat_q == LAST_BEAT) begin
                            state_d = TAIL;
                        end
                    end
                end
                TAIL, DROP: begin
                end
            endcase
            // A frame is good exactly when its last beat leaves us in TAIL,
            // which also covers Rlast landing on the final payload beat.
            if (RvviAxiRlast) begin
                good_d  = (state_d == TAIL);
                drop_d  = (state_d != TAIL);
                state_d = HDR;
                beat_d  = '0;
            end
        end
    end

    // Parser state, beat counter and shadow payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HDR;
            beat_q   <= '0;
            ipd_sh_q <= '0;
            min_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            ipd_sh_q <= ipd_sh_d;
            min_sh_q <= min_sh_d;
        end
    end

    // Publish the shadow payload (including a same-cycle final beat) on a good frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            ipd_q    <= '0;
            minstr_q <= '0;
        end else begin
            valid_q <= good_d;
            if (good_d) begin
                ipd_q    <= ipd_sh_d;
                minstr_q <= min_sh_d;
            end
        end
    end

    satcnt #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (good_d),
        .count_o (GoodFrames)
    );

    satcnt #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk     (clk),
        .rst     (reset),
        .inc_i   (drop_d),
        .count_o (DroppedFrames)
    );

    assign Valid            = valid_q;
    assign Minstr           = minstr_q[P.XLEN-1:0];
    assign InterPacketDelay = ipd_q;

endmodule
